// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the hazard controller state type.
// Also used by the ID stage so opcode/funct values live in one place.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard controller.
// Optional perf counters appear when HAZARD_PERF_CNT_EN is defined.
//
// Timing contract: there is no valid/ready handshake here. Inputs are sampled
// every cycle as a snapshot of IF_ID/ID_EX; control outputs are combinational
// for the current cycle and take effect on the next rising clk edge.
interface pipeline_hazard_ctrl_if #(
  parameter int SIZE     = 32,
  parameter int REG_BITS = $clog2(SIZE)
);
  import mips_pkg::*;

  logic [SIZE-1:0]     id_instr;
  logic                ex_mem_read;
  logic [REG_BITS-1:0] ex_dest;
  logic                branch_taken;

  logic                pc_write;
  logic                if_id_write;
  logic                if_id_flush;
  logic                id_ex_bubble;
  logic                md_start;
  logic                md_busy;
  ctrl_state_t         dbg_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [SIZE-1:0]     stall_cycles;
  logic [SIZE-1:0]     flush_count;

  modport master (
    output id_instr, ex_mem_read, ex_dest, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start, md_busy,
    input  dbg_state, stall_cycles, flush_count
  );
  modport slave (
    input  id_instr, ex_mem_read, ex_dest, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start, md_busy,
    output dbg_state, stall_cycles, flush_count
  );
`else
  modport master (
    output id_instr, ex_mem_read, ex_dest, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start, md_busy,
    input  dbg_state
  );
  modport slave (
    input  id_instr, ex_mem_read, ex_dest, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start, md_busy,
    output dbg_state
  );
`endif

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_decode.sv
// Combinational decode of the ID instruction into hazard classes,
// plus the load-use comparison against the load sitting in EX.
module hazard_decode
  import mips_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int REG_BITS = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]     i_id_instr,
  input  logic                i_ex_mem_read,
  input  logic [REG_BITS-1:0] i_ex_dest,
  output logic                o_is_md,
  output logic                o_is_hilo_rd,
  output logic                o_load_use
);

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [REG_BITS-1:0] w_rs;
  logic [REG_BITS-1:0] w_rt;
  logic                w_uses_rt;
  logic                w_unused_bits;

  assign w_op    = i_id_instr[31:26];
  assign w_funct = i_id_instr[5:0];
  assign w_rs    = i_id_instr[21 +: REG_BITS];
  assign w_rt    = i_id_instr[16 +: REG_BITS];
  // rd/shamt never participate in hazard detection
  assign w_unused_bits = ^i_id_instr[15:6];

  // Classify the instruction; r0 is hardwired so it never creates a hazard
  always_comb begin
    o_is_md      = (w_op == OP_RTYPE) &&
                   ((w_funct == FN_MULT) || (w_funct == FN_MULTU) ||
                    (w_funct == FN_DIV)  || (w_funct == FN_DIVU));
    o_is_hilo_rd = (w_op == OP_RTYPE) &&
                   ((w_funct == FN_MFHI) || (w_funct == FN_MFLO));
    w_uses_rt    = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                   (w_op == OP_BNE)   || (w_op == OP_SW);
    o_load_use   = i_ex_mem_read && (i_ex_dest != '0) &&
                   ((i_ex_dest == w_rs) || (w_uses_rt && (i_ex_dest == w_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush sequencer around the MIPS ID stage, owning the
// multi-cycle mult/div unit. Optional: HAZARD_PERF_CNT_EN adds saturating
// stall-cycle and flush counters.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int REG_BITS  = $clog2(SIZE),
  parameter int MD_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [REG_BITS:0] MD_LOAD = (REG_BITS+1)'(MD_CYCLES - 1);

  ctrl_state_t         r_state;
  logic [REG_BITS:0]   r_md_cnt;

  logic w_is_md;
  logic w_is_hilo_rd;
  logic w_load_use;
  logic w_md_stall;
  logic w_stall;
  logic w_md_start;

  hazard_decode #(
    .SIZE     (SIZE),
    .REG_BITS (REG_BITS)
  ) u_decode (
    .i_id_instr    (bus.id_instr),
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_dest     (bus.ex_dest),
    .o_is_md       (w_is_md),
    .o_is_hilo_rd  (w_is_hilo_rd),
    .o_load_use    (w_load_use)
  );

  assign w_md_stall = (r_state == MD_BUSY) && (w_is_md || w_is_hilo_rd);
  assign w_stall    = !bus.branch_taken && (w_md_stall || w_load_use);
  assign w_md_start = rst_n && !bus.branch_taken && !w_stall &&
                      (r_state == RUN) && w_is_md;

  // Prioritised pipeline controls: reset, branch flush, stall, free-run
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    if (!rst_n) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (w_stall) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

  assign bus.md_start  = w_md_start;
  assign bus.md_busy   = rst_n && (r_state == MD_BUSY);
  assign bus.dbg_state = r_state;

  // Mult/div occupancy: counter runs every busy cycle, stalls do not pause it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_md_start) begin
            r_state  <= MD_BUSY;
            r_md_cnt <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt == '0) r_state <= RUN;
          else                r_md_cnt <= r_md_cnt - 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [SIZE-1:0] r_stall_cycles;
  logic [SIZE-1:0] r_flush_count;

  // Saturating counters of stall cycles and branch flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (bus.branch_taken && !(&r_flush_count))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MD_CYCLES=4): directed
// scenarios followed by randomized instruction streams, checked against a
// cycle-level behavioural model that counts remaining busy cycles.
module tb_pipeline_hazard_ctrl;
  import mips_pkg::*;

  localparam int MDC = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   cyc;

  // model state
  int   busy_left;
  int   exp_stall;
  int   exp_flush;
  logic [31:0] exp_q[$];   // expected cycle of the next md_start in back-to-back runs
  logic        track_gap;

  pipeline_hazard_ctrl_if #(.SIZE(32)) bus ();

  pipeline_hazard_ctrl #(
    .SIZE      (32),
    .MD_CYCLES (MDC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return 32'((rs << 21) | (rt << 16) | (rd << 11) | fn);
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt);
    return 32'((op << 26) | (rs << 21) | (rt << 16) | 16'h0010);
  endfunction

  // Drive one cycle of inputs, check all outputs at the falling edge, advance model
  task automatic step(input logic [31:0] instr, input logic mr, input logic [4:0] dest,
                      input logic br);
    int  op, fn, rs, rt;
    bit  is_md, is_hilo, uses_rt, lu, busy, mdst, stall, start;
    bus.id_instr     = instr;
    bus.ex_mem_read  = mr;
    bus.ex_dest      = dest;
    bus.branch_taken = br;
    @(negedge clk);
    op      = int'(instr >> 26);
    fn      = int'(instr % 64);
    rs      = int'((instr >> 21) % 32);
    rt      = int'((instr >> 16) % 32);
    is_md   = (op == 0) && (fn >= 24) && (fn <= 27);
    is_hilo = (op == 0) && (fn == 16 || fn == 18);
    uses_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    lu      = mr && (dest != 0) && ((dest == rs) || (uses_rt && dest == rt));
    busy    = busy_left > 0;
    mdst    = busy && (is_md || is_hilo);
    stall   = rst_n && !br && (mdst || lu);
    start   = rst_n && !br && !stall && !busy && is_md;

    if (!rst_n) begin
      check("pc_write",  32'(bus.pc_write), 0);
      check("if_id_wr",  32'(bus.if_id_write), 0);
      check("flush",     32'(bus.if_id_flush), 1);
      check("bubble",    32'(bus.id_ex_bubble), 1);
    end else begin
      check("pc_write",  32'(bus.pc_write), 32'(!stall));
      check("if_id_wr",  32'(bus.if_id_write), 32'(!stall));
      check("flush",     32'(bus.if_id_flush), 32'(br));
      check("bubble",    32'(bus.id_ex_bubble), 32'(br || stall));
    end
    check("md_start", 32'(bus.md_start), 32'(start));
    check("md_busy",  32'(bus.md_busy), 32'(rst_n && busy));
    check("state",    32'(bus.dbg_state), busy ? 32'(MD_BUSY) : 32'(RUN));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", bus.stall_cycles, 32'(exp_stall));
    check("flush_cnt", bus.flush_count, 32'(exp_flush));
`endif

    if (track_gap && bus.md_start) begin
      if (exp_q.size() > 0) check("md_gap", 32'(cyc), exp_q.pop_front());
      exp_q.push_back(32'(cyc + MDC + 1));
    end

    if (!rst_n) begin
      busy_left = 0; exp_stall = 0; exp_flush = 0;
    end else begin
      if (busy)       busy_left--;
      else if (start) busy_left = MDC;
      if (stall && exp_stall != -1) exp_stall++;
      if (br && exp_flush != -1)    exp_flush++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [31:0] nop, add8, mult46, mfhi, div12;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    busy_left = 0; exp_stall = 0; exp_flush = 0; track_gap = 1'b0;
    nop    = 32'h0;
    add8   = rtype(8, 6, 9, 32);
    mult46 = rtype(4, 6, 0, int'(FN_MULT));
    mfhi   = rtype(0, 0, 3, int'(FN_MFHI));
    div12  = rtype(1, 2, 0, int'(FN_DIV));
    rst_n = 1'b0;
    bus.id_instr = '0; bus.ex_mem_read = 1'b0; bus.ex_dest = '0; bus.branch_taken = 1'b0;
    #1;

    // 1. reset held three cycles, even with a mult waiting in ID
    for (int i = 0; i < 3; i++) step(mult46, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    step(nop, 1'b0, 5'd0, 1'b0);

    // 2. load-use one cycle, then load gone; ex_dest=0 never stalls
    step(add8, 1'b1, 5'd8, 1'b0);
    step(add8, 1'b0, 5'd9, 1'b0);
    step(add8, 1'b1, 5'd0, 1'b0);
    step(itype(43, 3, 8), 1'b1, 5'd8, 1'b0);   // sw reads rt
    step(itype(35, 3, 8), 1'b1, 5'd8, 1'b0);   // lw does not read rt

    // 3. branch wins over load-use
    step(add8, 1'b1, 5'd8, 1'b1);

    // 4. mult issue, mfhi stalls, unrelated add flows
    step(mult46, 1'b0, 5'd0, 1'b0);
    step(add8, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(mfhi, 1'b0, 5'd0, 1'b0);
    step(nop, 1'b0, 5'd0, 1'b0);

    // 5. back-to-back div/div, then squashed mult under branch
    track_gap = 1'b1;
    for (int i = 0; i < 2 * (MDC + 1) + 1; i++) step(div12, 1'b0, 5'd0, 1'b0);
    track_gap = 1'b0;
    exp_q.delete();
    for (int i = 0; i < MDC + 1; i++) step(nop, 1'b0, 5'd0, 1'b0);
    step(mult46, 1'b0, 5'd0, 1'b1);

    // 6. reset asynchronously while the counter reads 2
    step(mult46, 1'b0, 5'd0, 1'b0);
    step(nop, 1'b0, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy",  32'(bus.md_busy), 0);
    check("async_state", 32'(bus.dbg_state), 32'(RUN));
    check("async_pcw",   32'(bus.pc_write), 0);
    busy_left = 0; exp_stall = 0; exp_flush = 0;
    step(nop, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    step(nop, 1'b0, 5'd0, 1'b0);

    // randomized instruction streams
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      int k, a, b;
      k = $urandom_range(0, 7);
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      case (k)
        0: ins = nop;
        1: ins = rtype(a, b, $urandom_range(0, 31), 32);
        2: ins = rtype(a, b, 0, 24 + $urandom_range(0, 3));
        3: ins = rtype(0, 0, b, ($urandom_range(0, 1) == 0) ? 16 : 18);
        4: ins = itype(35, a, b);
        5: ins = itype(43, a, b);
        6: ins = itype(($urandom_range(0, 1) == 0) ? 4 : 5, a, b);
        default: ins = $urandom;
      endcase
      step(ins, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline around the ID stage.
- Watches the instruction held in IF_ID and the instruction in ID_EX, and drives stall/flush controls for the PC, IF_ID and ID_EX registers.
- Detects load-use hazards, squashes wrong-path instructions on a taken branch, and owns a multi-cycle multiply/divide unit: issues its start and blocks HI/LO consumers until it finishes.

Parameters:
- SIZE, 32, datapath/instruction width and register count.
- REG_BITS, $clog2(SIZE), register index width.
- MD_CYCLES, 32, multiply/divide latency in cycles (>=2).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_instr  input  SIZE  instruction word, low half of IF_ID.
- ex_mem_read  input  1  instruction in ID_EX is a load.
- ex_dest  input  REG_BITS  destination register of the ID_EX instruction.
- branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- pc_write  output  1  PC register load enable.
- if_id_write  output  1  IF_ID load enable.
- if_id_flush  output  1  IF_ID clear to NOP on the next edge.
- id_ex_bubble  output  1  load ID_EX with NOP control instead of decoded ID.
- md_start  output  1  one-cycle start pulse to the mult/div unit.
- md_busy  output  1  mult/div unit occupied.

Behaviour:
- Decode from id_instr: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- is_md: op==0 and funct in {011000 mult, 011001 multu, 011010 div, 011011 divu}.
- is_hilo_rd: op==0 and funct in {010000 mfhi, 010010 mflo}.
- uses_rt: op in {000000, 000100, 000101, 101011}.
- load_use = ex_mem_read && ex_dest!=0 && (ex_dest==rs || (uses_rt && ex_dest==rt)).
- FSM states: RUN, MD_BUSY. Down-counter md_cnt is REG_BITS+1 bits wide.
- Per-cycle priority, highest first:
  1. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. An is_md in ID is squashed (no md_start). An op already in MD_BUSY continues.
  2. md_stall = (state==MD_BUSY) && (is_md || is_hilo_rd): pc_write=0, if_id_write=0, id_ex_bubble=1.
  3. load_use: same outputs as md_stall, for one cycle only. The next cycle the load has left EX and the condition clears naturally.
  4. Otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0.
- md_start=1 only when state==RUN, is_md, and none of cases 1-3 apply. On that edge: state->MD_BUSY, md_cnt<=MD_CYCLES-1.
- In MD_BUSY, md_cnt decrements every cycle regardless of stalls. When md_cnt==0, state->RUN on that edge. md_busy is asserted in MD_BUSY, including the final cycle.
- Back-to-back: an is_md waiting in ID during the last MD_BUSY cycle still stalls, then issues in the first RUN cycle. Total gap is MD_CYCLES+1 cycles between md_start pulses.
- Control outputs (pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start) are combinational from state, counter and inputs. State and counter are registered.
- Reset (rst_n low, asynchronous): state=RUN, md_cnt=0. Outputs forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, md_start=0, md_busy=0.
- Reset asserted mid-MD_BUSY aborts the op. The unit is assumed reset by the same rst_n.
- Register 0 is never a hazard source.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined: adds outputs stall_cycles[SIZE-1:0] and flush_count[SIZE-1:0], both reset to 0.
  - stall_cycles increments on every cycle with a case 2 or 3 stall.
  - flush_count increments on every branch_taken cycle.
  - Both saturate at all-ones.
- When undefined: ports and counters are absent, with no other change.

Decomposition:
- Shared package mips_pkg holds the opcode/funct localparams (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, FN_MULT..FN_DIVU, FN_MFHI, FN_MFLO) and the ctrl_state_t enum {RUN, MD_BUSY}. The ID stage reuses the same constants.
- One natural sub-module, hazard_decode: combinational, computes is_md, is_hilo_rd, uses_rt and load_use from id_instr/ex_dest/ex_mem_read.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles -> pc_write=0, if_id_flush=1, id_ex_bubble=1, md_busy=0. Release -> RUN, with pc_write=1 given a NOP in ID.
2. Load-use: ex_mem_read=1, ex_dest=8, id_instr=add rs=8 rt=6 rd=9 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_dest=0 -> no stall.
3. Branch flush: branch_taken=1 together with the load-use condition from scenario 2 -> if_id_flush=1, id_ex_bubble=1, pc_write=1 (flush wins).
4. Mult issue: id_instr=mult rs=4 rt=6, MD_CYCLES=4 -> md_start pulses once; md_busy high for exactly 4 cycles. Then mfhi in ID -> stalled for 3 cycles, proceeds once md_busy drops. An unrelated add during busy -> no stall.
5. Back-to-back div/div: second div stalls; md_start pulses are exactly MD_CYCLES+1 cycles apart. Mult in ID with branch_taken -> no md_start.
6. Reset asserted mid-MD_BUSY (count=2) -> md_busy drops immediately (async), state RUN. With HAZARD_PERF_CNT_EN, stall_cycles and flush_count match scenarios 2-5 totals.
